// File: rtl/ddram_wr_merge_pkg.sv
// ddram_wr_merge_pkg
//   Shared definitions for the rotated-framebuffer DDRAM write path. The pixel
//   writer and the write-combining buffer both import this package, so they
//   agree on entry field widths and on the fixed Avalon side-band values.
//   Contents:
//     AW_DEFAULT      default DDRAM word-address width (64-bit words)
//     DATA_W / BE_W   write data width and byte-enable width
//     DDRAM_BURSTCNT_C, DDRAM_RD_C   constant Avalon burst count / read strobe
//     merge_bytes()   byte-wise overlay of new data onto old data

package ddram_wr_merge_pkg;

    localparam int AW_DEFAULT = 29;
    localparam int DATA_W     = 64;
    localparam int BE_W       = 8;

    localparam logic [7:0] DDRAM_BURSTCNT_C = 8'd1;
    localparam logic       DDRAM_RD_C       = 1'b0;

    // Bytes whose enable is set take the new value; others keep the old one.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_d,
        input logic [DATA_W-1:0] new_d,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] r;
        r = old_d;
        for (int unsigned i = 0; i < BE_W; i++) begin
            if (be[i]) r[i*8 +: 8] = new_d[i*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/ddram_wr_merge_if.sv
// ddram_wr_merge_if
//   Avalon-MM write port towards DDRAM. Member names match the original
//   top-level port names so existing wiring maps one to one.
//   master: the write source (drives address/data/strobes, samples BUSY)
//   slave : the DDRAM controller side
//   DDRAM_BUSY      waitrequest
//   DDRAM_BURSTCNT  burst count
//   DDRAM_ADDR      64-bit word address
//   DDRAM_DIN       write data
//   DDRAM_BE        byte enables
//   DDRAM_WE        write request
//   DDRAM_RD        read request

interface ddram_wr_merge_if #(
    parameter int AW = 29
);
    import ddram_wr_merge_pkg::*;

    logic                DDRAM_BUSY;
    logic [7:0]          DDRAM_BURSTCNT;
    logic [AW-1:0]       DDRAM_ADDR;
    logic [DATA_W-1:0]   DDRAM_DIN;
    logic [BE_W-1:0]     DDRAM_BE;
    logic                DDRAM_WE;
    logic                DDRAM_RD;

    modport master (
        input  DDRAM_BUSY,
        output DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_DIN, DDRAM_BE, DDRAM_WE, DDRAM_RD
    );

    modport slave (
        output DDRAM_BUSY,
        input  DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_DIN, DDRAM_BE, DDRAM_WE, DDRAM_RD
    );

endinterface

// File: rtl/ddram_wr_fifo.sv
// ddram_wr_fifo
//   Synchronous FIFO of DDRAM write entries with a registered head stage that
//   drives the Avalon write strobe directly. The head entry counts towards
//   level, so level is the total number of writes not yet accepted by DDRAM.
//   Ports:
//     clk, rst_n         clock, asynchronous active-low reset
//     push, push_*       entry to enqueue this cycle
//     push_ready         push will be accepted (room, or a pop this cycle)
//     busy               Avalon waitrequest
//     head_we, head_*    registered head entry / write request
//     level              occupancy, 0..DEPTH

module ddram_wr_fifo
    import ddram_wr_merge_pkg::*;
#(
    parameter int AW         = AW_DEFAULT,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [AW-1:0]         push_addr,
    input  logic [DATA_W-1:0]     push_din,
    input  logic [BE_W-1:0]       push_be,
    output logic                  push_ready,
    input  logic                  busy,
    output logic                  head_we,
    output logic [AW-1:0]         head_addr,
    output logic [DATA_W-1:0]     head_din,
    output logic [BE_W-1:0]       head_be,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;
    localparam int EW    = AW + DATA_W + BE_W;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    logic [EW-1:0]          mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]          level_q, level_d;
    logic [LW-1:0]          avail;
    logic                   we_q, we_d;
    logic [EW-1:0]          head_q, head_d;
    logic                   pop;
    logic                   accept;

    always_comb begin
        pop        = we_q & ~busy;
        push_ready = (level_q != FULL) | pop;
        accept     = push & push_ready;
        rd_ptr_d   = rd_ptr_q + DEPTH_LOG2'(pop);
        wr_ptr_d   = wr_ptr_q + DEPTH_LOG2'(accept);
        level_d    = level_q + LW'(accept) - LW'(pop);
        // Entries already in memory that remain after this edge's pop; an
        // entry pushed this cycle is not yet readable and appears one cycle
        // later.
        avail      = level_q - LW'(pop);
        we_d       = we_q;
        head_d     = head_q;
        if (!(we_q && busy)) begin
            we_d = (avail != '0);
            if (avail != '0) head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            we_q     <= 1'b0;
            head_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
            we_q     <= we_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem_q[wr_ptr_q] <= {push_addr, push_din, push_be};
    end

    assign head_we                         = we_q;
    assign {head_addr, head_din, head_be}  = head_q;
    assign level                           = level_q;

endmodule

// File: rtl/ddram_wr_merge.sv
// ddram_wr_merge
//   Write-combining buffer between the rotated-framebuffer pixel writer and the
//   DDRAM Avalon port. Half-word writes to the same 64-bit word are merged in a
//   single hold register, then queued and issued only while BUSY is low.
//   Ports:
//     clk_video, rst_n   clock, asynchronous active-low reset
//     in_wr/in_addr/in_din/in_be   write from the pixel writer (no stall)
//     flush              push the hold register at the next in_wr-free cycle
//     ddram              Avalon write master (ddram_wr_merge_if.master)
//     level              queued writes including the one on DDRAM_WE
//     overflow           sticky, set when an entry had to be dropped
//     drop_cnt           dropped entries, saturating
//     idle               nothing held, nothing queued, no write pending

module ddram_wr_merge
    import ddram_wr_merge_pkg::*;
#(
    parameter int AW         = AW_DEFAULT,
    parameter int DEPTH_LOG2 = 4,
    parameter int FLUSH_TO   = 8
) (
    input  logic                  clk_video,
    input  logic                  rst_n,
    input  logic                  in_wr,
    input  logic [AW-1:0]         in_addr,
    input  logic [DATA_W-1:0]     in_din,
    input  logic [BE_W-1:0]       in_be,
    input  logic                  flush,
    ddram_wr_merge_if.master      ddram,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic [15:0]           drop_cnt,
    output logic                  idle
);

    localparam logic [7:0] TO_LAST = 8'(FLUSH_TO - 1);

    logic                hold_v_q, hold_v_d;
    logic [AW-1:0]       hold_addr_q, hold_addr_d;
    logic [DATA_W-1:0]   hold_din_q, hold_din_d;
    logic [BE_W-1:0]     hold_be_q, hold_be_d;
    logic [7:0]          timer_q, timer_d;
    logic                flush_pend_q, flush_pend_d;
    logic                overflow_q, overflow_d;
    logic [15:0]         drop_cnt_q, drop_cnt_d;

    logic                push;
    logic                push_ready;
    logic                head_we;

    always_comb begin
        hold_v_d     = hold_v_q;
        hold_addr_d  = hold_addr_q;
        hold_din_d   = hold_din_q;
        hold_be_d    = hold_be_q;
        timer_d      = timer_q;
        flush_pend_d = flush_pend_q;
        overflow_d   = overflow_q;
        drop_cnt_d   = drop_cnt_q;
        push         = 1'b0;

        if (in_wr) begin
            // A flush seen during a write waits for the next write-free cycle.
            flush_pend_d = flush_pend_q | flush;
            timer_d      = '0;
            hold_v_d     = 1'b1;
            if (hold_v_q && (in_addr == hold_addr_q)) begin
                hold_din_d = merge_bytes(hold_din_q, in_din, in_be);
                hold_be_d  = hold_be_q | in_be;
            end else begin
                push        = hold_v_q;
                hold_addr_d = in_addr;
                hold_din_d  = in_din;
                hold_be_d   = in_be;
            end
        end else if (hold_v_q) begin
            if ((timer_q == TO_LAST) || flush_pend_q || flush) begin
                push         = 1'b1;
                hold_v_d     = 1'b0;
                flush_pend_d = 1'b0;
                timer_d      = '0;
            end else begin
                timer_d = timer_q + 8'd1;
            end
        end else begin
            flush_pend_d = 1'b0;
        end

        if (push && !push_ready) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_video or negedge rst_n) begin
        if (!rst_n) begin
            hold_v_q     <= 1'b0;
            hold_addr_q  <= '0;
            hold_din_q   <= '0;
            hold_be_q    <= '0;
            timer_q      <= '0;
            flush_pend_q <= 1'b0;
            overflow_q   <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            hold_v_q     <= hold_v_d;
            hold_addr_q  <= hold_addr_d;
            hold_din_q   <= hold_din_d;
            hold_be_q    <= hold_be_d;
            timer_q      <= timer_d;
            flush_pend_q <= flush_pend_d;
            overflow_q   <= overflow_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    ddram_wr_fifo #(
        .AW         (AW),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk        (clk_video),
        .rst_n      (rst_n),
        .push       (push),
        .push_addr  (hold_addr_q),
        .push_din   (hold_din_q),
        .push_be    (hold_be_q),
        .push_ready (push_ready),
        .busy       (ddram.DDRAM_BUSY),
        .head_we    (head_we),
        .head_addr  (ddram.DDRAM_ADDR),
        .head_din   (ddram.DDRAM_DIN),
        .head_be    (ddram.DDRAM_BE),
        .level      (level)
    );

    assign ddram.DDRAM_WE       = head_we;
    assign ddram.DDRAM_BURSTCNT = DDRAM_BURSTCNT_C;
    assign ddram.DDRAM_RD       = DDRAM_RD_C;

    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;
    assign idle     = ~hold_v_q & (level == '0) & ~head_we;

endmodule

// File: tb/tb_ddram_wr_merge.sv
// tb_ddram_wr_merge
//   Directed scenarios plus a randomized phase. A transaction-level model
//   (hold word, queue of pending writes each tagged with the cycle it becomes
//   visible on the bus) predicts the DDRAM port every cycle.

module tb_ddram_wr_merge;

    localparam int AW    = 29;
    localparam int DL    = 4;
    localparam int FTO   = 8;
    localparam int DEPTH = 16;

    logic          clk_video = 1'b0;
    logic          rst_n;
    logic          in_wr;
    logic [AW-1:0] in_addr;
    logic [63:0]   in_din;
    logic [7:0]    in_be;
    logic          flush;
    logic          busy;
    logic [DL:0]   level;
    logic          overflow;
    logic [15:0]   drop_cnt;
    logic          idle;

    always #5 clk_video = ~clk_video;

    ddram_wr_merge_if #(.AW(AW)) dif ();
    assign dif.DDRAM_BUSY = busy;

    ddram_wr_merge #(
        .AW         (AW),
        .DEPTH_LOG2 (DL),
        .FLUSH_TO   (FTO)
    ) dut (
        .clk_video (clk_video),
        .rst_n     (rst_n),
        .in_wr     (in_wr),
        .in_addr   (in_addr),
        .in_din    (in_din),
        .in_be     (in_be),
        .flush     (flush),
        .ddram     (dif.master),
        .level     (level),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .idle      (idle)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [AW-1:0] addr;
        logic [63:0]   din;
        logic [7:0]    be;
        int            ready;   // first cycle this entry can be on DDRAM_WE
    } ent_t;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [63:0]   din;
        logic [7:0]    be;
    } obs_t;

    ent_t          mq[$];
    obs_t          obs[$];
    int            cyc;
    bit            m_hv;
    logic [AW-1:0] m_ha;
    logic [63:0]   m_hd;
    logic [7:0]    m_hb;
    int            m_timer;
    bit            m_fp;
    bit            m_ovf;
    int            m_drops;

    task automatic model_reset();
        mq.delete();
        m_hv = 0; m_ha = '0; m_hd = '0; m_hb = '0;
        m_timer = 0; m_fp = 0; m_ovf = 0; m_drops = 0;
    endtask

    task automatic model_step();
        bit   pop;
        bit   do_push;
        ent_t e;
        pop     = (mq.size() > 0) && (mq[0].ready <= cyc) && !busy;
        do_push = 0;
        e       = '{addr: m_ha, din: m_hd, be: m_hb, ready: cyc + 2};
        if (in_wr) begin
            if (m_hv && in_addr == m_ha) begin
                for (int b = 0; b < 8; b++)
                    if (in_be[b]) m_hd[b*8 +: 8] = in_din[b*8 +: 8];
                m_hb = m_hb | in_be;
            end else begin
                do_push = m_hv;
                m_ha = in_addr; m_hd = in_din; m_hb = in_be;
            end
            m_hv = 1; m_timer = 0; m_fp = m_fp | flush;
        end else if (m_hv) begin
            if (m_timer == FTO - 1 || m_fp || flush) begin
                do_push = 1; m_hv = 0; m_fp = 0; m_timer = 0;
            end else begin
                m_timer++;
            end
        end else begin
            m_fp = 0;
        end
        if (do_push && !(mq.size() < DEPTH || pop)) begin
            m_ovf = 1;
            if (m_drops < 65535) m_drops++;
            do_push = 0;
        end
        if (pop) mq.delete(0);
        if (do_push) mq.push_back(e);
        cyc++;
    endtask

    // One clock cycle with the inputs currently driven.
    task automatic step();
        bit exp_we;
        @(negedge clk_video);
        exp_we = (mq.size() > 0) && (mq[0].ready <= cyc);
        check_eq("we", dif.DDRAM_WE, exp_we);
        if (exp_we) begin
            check_eq("addr", dif.DDRAM_ADDR, mq[0].addr);
            check_eq("din", dif.DDRAM_DIN, mq[0].din);
            check_eq("be", dif.DDRAM_BE, mq[0].be);
        end
        check_eq("level", level, mq.size());
        check_eq("ovf", overflow, m_ovf);
        check_eq("drops", drop_cnt, m_drops);
        check_eq("idle", idle, !m_hv && mq.size() == 0);
        if (dif.DDRAM_WE && !busy)
            obs.push_back('{cyc: cyc, addr: dif.DDRAM_ADDR, din: dif.DDRAM_DIN, be: dif.DDRAM_BE});
        model_step();
        @(posedge clk_video);
        #1;
    endtask

    task automatic drive(input bit wr, input logic [AW-1:0] a, input logic [63:0] d,
                         input logic [7:0] b, input bit f);
        in_wr = wr; in_addr = a; in_din = d; in_be = b; flush = f;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [63:0] d, input logic [7:0] b);
        drive(1, a, d, b, 0);
        step();
    endtask

    task automatic idle_steps(input int n);
        drive(0, '0, '0, '0, 0);
        repeat (n) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        int stable;
        int pct;
        logic [AW-1:0] last_a;

        rst_n = 1'b1; busy = 1'b0; cyc = 0;
        drive(0, '0, '0, '0, 0);
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_we", dif.DDRAM_WE, 0);
        check_eq("rst_level", level, 0);
        check_eq("rst_ovf", overflow, 0);
        check_eq("rst_drops", drop_cnt, 0);
        check_eq("rst_idle", idle, 1);
        check_eq("rst_addr", dif.DDRAM_ADDR, 0);
        check_eq("rst_din", dif.DDRAM_DIN, 0);
        check_eq("rst_be", dif.DDRAM_BE, 0);
        check_eq("burstcnt", dif.DDRAM_BURSTCNT, 1);
        check_eq("rd", dif.DDRAM_RD, 0);
        repeat (2) @(posedge clk_video);
        #1 rst_n = 1'b1;

        // Merge of two halves into one write
        obs.delete(); t0 = cyc;
        wr('h100, 64'h0000_0000_1122_3344, 8'h0F);
        wr('h100, 64'hAABB_CCDD_0000_0000, 8'hF0);
        idle_steps(FTO + 6);
        check_eq("merge_n", obs.size(), 1);
        if (obs.size() > 0) begin
            check_eq("merge_cyc", obs[0].cyc, t0 + FTO + 3);
            check_eq("merge_addr", obs[0].addr, 'h100);
            check_eq("merge_be", obs[0].be, 8'hFF);
            check_eq("merge_din", obs[0].din, 64'hAABBCCDD11223344);
        end

        // Overlapping bytes: later write wins
        obs.delete();
        wr('h20, 64'h0000_0000_0000_FFFF, 8'h0F);
        wr('h20, 64'h0000_0000_0000_1234, 8'h03);
        idle_steps(FTO + 6);
        check_eq("ovl_n", obs.size(), 1);
        if (obs.size() > 0) begin
            check_eq("ovl_be", obs[0].be, 8'h0F);
            check_eq("ovl_din", obs[0].din, 64'h1234);
        end

        // Backpressure
        busy = 1'b1; obs.delete();
        wr('h1, 64'h1111, 8'hFF);
        wr('h2, 64'h2222, 8'hFF);
        wr('h3, 64'h3333, 8'hFF);
        drive(0, '0, '0, '0, 1); step();
        drive(0, '0, '0, '0, 0);
        stable = 0;
        repeat (10) begin
            if (dif.DDRAM_WE && dif.DDRAM_ADDR == 'h1) stable++;
            step();
        end
        check_eq("bp_stable", stable, 10);
        busy = 1'b0;
        idle_steps(8);
        check_eq("bp_n", obs.size(), 3);
        if (obs.size() == 3) begin
            check_eq("bp_a0", obs[0].addr, 'h1);
            check_eq("bp_a1", obs[1].addr, 'h2);
            check_eq("bp_a2", obs[2].addr, 'h3);
            check_eq("bp_c1", obs[1].cyc, obs[0].cyc + 1);
            check_eq("bp_c2", obs[2].cyc, obs[0].cyc + 2);
        end
        check_eq("bp_idle", idle, 1);
        check_eq("bp_we", dif.DDRAM_WE, 0);

        // Overflow
        busy = 1'b1; obs.delete();
        for (int i = 0; i < 18; i++) wr(AW'(i), 64'(i) * 64'h0101, 8'hFF);
        check_eq("of_level", level, 16);
        check_eq("of_ovf", overflow, 1);
        check_eq("of_drops", drop_cnt, 1);
        check_eq("of_idle", idle, 0);
        busy = 1'b0;
        idle_steps(40);
        check_eq("of_n", obs.size(), 17);
        for (int k = 0; k < 17 && k < obs.size(); k++)
            check_eq("of_order", obs[k].addr, (k < 16) ? k : 17);

        // Flush collision and empty flush
        obs.delete(); t0 = cyc;
        wr('h3F, 64'h3F, 8'hFF);
        drive(1, 'h40, 64'h40, 8'hFF, 1); step();
        idle_steps(10);
        check_eq("fc_n", obs.size(), 2);
        if (obs.size() == 2) begin
            check_eq("fc_a0", obs[0].addr, 'h3F);
            check_eq("fc_c0", obs[0].cyc, t0 + 3);
            check_eq("fc_a1", obs[1].addr, 'h40);
            check_eq("fc_c1", obs[1].cyc, t0 + 4);
        end
        obs.delete();
        drive(0, '0, '0, '0, 1); step();
        idle_steps(15);
        check_eq("fe_n", obs.size(), 0);

        // Asynchronous reset mid-stream
        busy = 1'b1;
        for (int i = 0; i < 6; i++) wr(AW'('h200 + i), 64'(i), 8'hFF);
        drive(0, '0, '0, '0, 0);
        check_eq("ar_pre_we", dif.DDRAM_WE, 1);
        check_eq("ar_pre_level", level, 5);
        #2 rst_n = 1'b0;
        #1;
        check_eq("ar_we", dif.DDRAM_WE, 0);
        check_eq("ar_level", level, 0);
        check_eq("ar_ovf", overflow, 0);
        check_eq("ar_drops", drop_cnt, 0);
        check_eq("ar_idle", idle, 1);
        model_reset();
        busy = 1'b0;
        @(posedge clk_video);
        #1 rst_n = 1'b1;
        obs.delete();
        idle_steps(30);
        check_eq("ar_quiet", obs.size(), 0);

        // Randomized traffic
        pct = 0; last_a = '0;
        for (int n = 0; n < 4000; n++) begin
            if (n % 200 == 0) begin
                case ($urandom_range(0, 3))
                    0: pct = 0;
                    1: pct = 30;
                    2: pct = 70;
                    default: pct = 95;
                endcase
            end
            busy    = ($urandom_range(0, 99) < pct);
            in_wr   = ($urandom_range(0, 99) < 55);
            in_addr = ($urandom_range(0, 1) == 1) ? last_a : AW'($urandom_range(0, 15));
            last_a  = in_addr;
            in_din  = {$urandom, $urandom};
            in_be   = 8'($urandom);
            flush   = ($urandom_range(0, 99) < 3);
            step();
        end
        busy = 1'b0;
        idle_steps(60);
        check_eq("end_idle", idle, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
